ebr_spi_reader: RTL and testbench
=================================

Name: ebr_spi_reader

Overview:
Reads a completed camera line out of the 512x8 line-buffer EBR and streams it to the host over the SPI slave pins (mode 0, MSB first). It is the read-side counterpart of the camera capture writer: the capture side writes a line, and this block drains that line to the host. It runs entirely in the xclk domain. sck and scsn are oversampled through synchronisers; xclk must be at least 8x the sck frequency.

Parameters:
ADDR_W, 9, EBR address width (512 entries).
HDR, 8'hA5, header byte sent first when a line is pending.
FILL, 8'hFF, byte sent when no line is pending or after the line data.

Ports:
xclk  in  1  system clock
rstn  in  1  asynchronous active-low reset
sck  in  1  SPI clock, asynchronous to xclk
scsn  in  1  SPI chip select, active low, asynchronous to xclk
miso  out  1  SPI data out
misoOe  out  1  miso output enable, 1 while the transaction is active
lineValid  in  1  one-cycle pulse: a line is complete in the EBR
lineLen  in  10  byte count of the line, sampled on lineValid
ebrRAddr  out  9  EBR read address
ebrRE  out  1  EBR read enable; data is valid on ebrRData one xclk later
ebrRData  in  8  EBR read data
lineDone  out  1  one-cycle pulse: last data byte fully shifted out
overrun  out  1  one-cycle pulse: lineValid arrived while a line was already pending
aborted  out  1  one-cycle pulse: scsn rose before all line bytes were sent

Behaviour:
- Reset values: miso=0, misoOe=0, ebrRAddr=0, ebrRE=0, lineDone=0, overrun=0, aborted=0, pending=0, state=IDLE.
- Synchronisers: two flip-flops each on sck and scsn, plus a third stage for edge detection. Derived strobes are sckRise, sckFall, csFall, csRise. Synchroniser latency is 3 xclk.
- misoOe = inverse of the synchronised scsn. miso = shift[7], registered.
- lineValid handling:
  - lineLen 0: ignored.
  - lineLen >512: clamped to 512.
  - If pending=0: set pending=1 and latch len.
  - If pending=1 and not in the same cycle as lineDone: pulse overrun and keep the old line.
  - lineValid in the same cycle as lineDone: accepted as the new pending line.
- FSM states: IDLE, HDR, DATA, PAD.
  - IDLE, on csFall:
    - pending=1: shift<=HDR, go to HDR, ebrRE=1 with ebrRAddr=0.
    - pending=0: shift<=FILL, go to PAD.
    - In both cases bitCnt<=0 and byteIdx<=0.
  - Byte framing, all states:
    - bitCnt (3 bits) increments on sckRise.
    - The rise that wraps bitCnt 7->0 is byteEnd.
    - On sckFall when not byteEnd-pending: shift<=shift<<1.
    - On the first sckFall after byteEnd: shift<=nextByte.
  - Prefetch: ebrRData is captured into nextByte the cycle after ebrRE. ebrRE is a single-cycle pulse. The next address is issued at each byteEnd in HDR/DATA, so a byte is always ready 8 sck periods early.
  - HDR: at byteEnd go to DATA; nextByte holds EBR[0]; issue read of addr 1.
  - DATA:
    - Each byteEnd increments byteIdx.
    - At byteEnd with byteIdx==len-1: pulse lineDone, clear pending, nextByte<=FILL, go to PAD.
    - Addresses beyond len-1 are never read; ebrRAddr holds its value.
  - PAD: every byte is FILL until csRise.
- csRise in any non-IDLE state: go to IDLE and drive shift to 0.
  - If state is HDR or DATA (line not finished), pulse aborted. pending stays 1, so the next transaction restarts from addr 0 with the header.
  - A csRise on the same cycle as the final byteEnd counts as finished: lineDone is pulsed, aborted is not.
- A line that becomes pending mid-transaction (in PAD) is not sent until the next csFall.
- Partial bytes (fewer than 8 rises before csRise) are discarded. bitCnt resets at csFall.
- rstn asserted mid-transaction: everything returns to reset values immediately and pending is lost. After release the block ignores any transaction in progress until the next csFall.

Test Plan:
1. lineValid with lineLen=4, EBR=11,22,33,44; transaction of 6 bytes (sck = xclk/8) -> miso bytes A5,11,22,33,44,FF; lineDone pulses once at the end of byte 5; ebrRAddr sequence 0,1,2,3.
2. No line pending; transaction of 2 bytes -> FF,FF; no lineDone, no aborted, no EBR reads.
3. lineLen=4; scsn rises after 2 bytes -> aborted pulses. The next transaction returns A5,11,22,33,44 and lineDone fires.
4. lineValid twice, with no transaction between -> overrun pulses once; the first lineLen is kept.
5. lineLen=512, EBR[i]=i[7:0] -> 513 bytes: A5 followed by 00..FF twice; ebrRAddr reaches 0x1FF and does not wrap. lineLen=600 gives an identical result (clamp).
6. Assert rstn low mid-DATA -> miso=0, misoOe=0, no pending. A following transaction returns FF.

Source files
------------

// File: rtl/ebr_spi_reader.sv
// Drains a completed camera line from the 512x8 line-buffer EBR to the host over an SPI
// mode-0 slave port. sck/scsn are oversampled in the xclk domain (xclk >= 8x sck).
module ebr_spi_reader #(
   parameter int unsigned ADDR_W = 9,
   parameter logic [7:0]  HDR    = 8'hA5,
   parameter logic [7:0]  FILL   = 8'hFF
) (
   input  logic              xclk,
   input  logic              rstn,
   input  logic              sck,
   input  logic              scsn,
   output logic              miso,
   output logic              misoOe,
   input  logic              lineValid,
   input  logic [ADDR_W:0]   lineLen,
   output logic [ADDR_W-1:0] ebrRAddr,
   output logic              ebrRE,
   input  logic [7:0]        ebrRData,
   output logic              lineDone,
   output logic              overrun,
   output logic              aborted
);

   localparam int unsigned LW = ADDR_W + 1;

   typedef enum logic [1:0] {StIdle, StHdr, StData, StPad} state_t;

   state_t            r_state, w_state_d;
   logic [2:0]        r_sck_q, r_cs_q;
   logic [7:0]        r_shift, w_shift_d;
   logic [7:0]        r_next, w_next_d;
   logic [7:0]        r_hold, w_hold_d;
   logic              r_load, w_load_d;
   logic [2:0]        r_bit_cnt, w_bit_cnt_d;
   logic [LW-1:0]     r_byte_idx, w_byte_idx_d;
   logic [LW-1:0]     r_len, w_len_d;
   logic              r_pending, w_pending_d;
   logic [ADDR_W-1:0] r_addr, w_addr_d;
   logic              r_re, w_re_d;
   logic              r_cap;
   logic              r_oe;
   logic              r_done, w_done_d;
   logic              r_ovr, w_ovr_d;
   logic              r_abt, w_abt_d;

   logic              w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
   logic              w_byte_end, w_final;
   logic [LW-1:0]     w_max, w_len_in, w_addr_nxt;

   assign w_sck_rise = r_sck_q[1] & ~r_sck_q[2];
   assign w_sck_fall = ~r_sck_q[1] & r_sck_q[2];
   assign w_cs_fall  = ~r_cs_q[1] & r_cs_q[2];
   assign w_cs_rise  = r_cs_q[1] & ~r_cs_q[2];
   assign w_byte_end = w_sck_rise & (r_bit_cnt == 3'd7);
   assign w_max      = LW'(1 << ADDR_W);
   assign w_len_in   = (lineLen > w_max) ? w_max : lineLen;
   assign w_addr_nxt = {1'b0, r_addr} + LW'(1);
   assign w_final    = (r_state == StData) & w_byte_end & (r_byte_idx == r_len - LW'(1));

   assign miso     = r_shift[7];
   assign misoOe   = r_oe;
   assign ebrRAddr = r_addr;
   assign ebrRE    = r_re;
   assign lineDone = r_done;
   assign overrun  = r_ovr;
   assign aborted  = r_abt;

   always_comb begin
      w_state_d    = r_state;
      w_shift_d    = r_shift;
      w_next_d     = r_next;
      w_hold_d     = r_hold;
      w_load_d     = r_load;
      w_bit_cnt_d  = r_bit_cnt;
      w_byte_idx_d = r_byte_idx;
      w_len_d      = r_len;
      w_pending_d  = r_pending;
      w_addr_d     = r_addr;
      w_re_d       = 1'b0;
      w_done_d     = 1'b0;
      w_ovr_d      = 1'b0;
      w_abt_d      = 1'b0;

      if (r_cap) w_next_d = ebrRData;

      if (r_state != StIdle) begin
         if (w_sck_rise) w_bit_cnt_d = r_bit_cnt + 3'd1;
         if (w_byte_end) w_load_d = 1'b1;
         if (w_sck_fall) begin
            if (r_load) begin
               w_shift_d = r_hold;
               w_load_d  = 1'b0;
            end else begin
               w_shift_d = {r_shift[6:0], 1'b0};
            end
         end
      end

      // r_hold carries the byte for the coming load while r_next receives the next prefetch.
      unique case (r_state)
         StIdle: begin
            if (w_cs_fall) begin
               w_bit_cnt_d  = 3'd0;
               w_byte_idx_d = '0;
               w_load_d     = 1'b0;
               if (r_pending) begin
                  w_shift_d = HDR;
                  w_state_d = StHdr;
                  w_re_d    = 1'b1;
                  w_addr_d  = '0;
               end else begin
                  w_shift_d = FILL;
                  w_hold_d  = FILL;
                  w_state_d = StPad;
               end
            end
         end
         StHdr: begin
            if (w_byte_end) begin
               w_state_d = StData;
               w_hold_d  = r_next;
               if (w_addr_nxt < r_len) begin
                  w_re_d   = 1'b1;
                  w_addr_d = w_addr_nxt[ADDR_W-1:0];
               end
            end
         end
         StData: begin
            if (w_byte_end) begin
               w_byte_idx_d = r_byte_idx + LW'(1);
               if (w_final) begin
                  w_done_d  = 1'b1;
                  w_hold_d  = FILL;
                  w_next_d  = FILL;
                  w_state_d = StPad;
               end else begin
                  w_hold_d = r_next;
                  if (w_addr_nxt < r_len) begin
                     w_re_d   = 1'b1;
                     w_addr_d = w_addr_nxt[ADDR_W-1:0];
                  end
               end
            end
         end
         StPad: begin
            if (w_byte_end) w_hold_d = FILL;
         end
         default: w_state_d = StIdle;
      endcase

      if ((r_state != StIdle) && w_cs_rise) begin
         w_state_d = StIdle;
         w_shift_d = 8'h00;
         w_load_d  = 1'b0;
         w_abt_d   = ((r_state == StHdr) || (r_state == StData)) && !w_final;
      end

      if (w_final) w_pending_d = 1'b0;
      if (lineValid && (lineLen != '0)) begin
         if (!r_pending || w_final) begin
            w_pending_d = 1'b1;
            w_len_d     = w_len_in;
         end else begin
            w_ovr_d = 1'b1;
         end
      end
   end

   // Chip-select synchroniser resets to "asserted" so a select already low at reset release
   // produces no csFall and is ignored.
   always_ff @(posedge xclk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= StIdle;
         r_sck_q    <= 3'b000;
         r_cs_q     <= 3'b000;
         r_shift    <= 8'h00;
         r_next     <= 8'h00;
         r_hold     <= 8'h00;
         r_load     <= 1'b0;
         r_bit_cnt  <= 3'd0;
         r_byte_idx <= '0;
         r_len      <= '0;
         r_pending  <= 1'b0;
         r_addr     <= '0;
         r_re       <= 1'b0;
         r_cap      <= 1'b0;
         r_oe       <= 1'b0;
         r_done     <= 1'b0;
         r_ovr      <= 1'b0;
         r_abt      <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_sck_q    <= {r_sck_q[1:0], sck};
         r_cs_q     <= {r_cs_q[1:0], scsn};
         r_shift    <= w_shift_d;
         r_next     <= w_next_d;
         r_hold     <= w_hold_d;
         r_load     <= w_load_d;
         r_bit_cnt  <= w_bit_cnt_d;
         r_byte_idx <= w_byte_idx_d;
         r_len      <= w_len_d;
         r_pending  <= w_pending_d;
         r_addr     <= w_addr_d;
         r_re       <= w_re_d;
         r_cap      <= r_re;
         r_oe       <= (w_state_d != StIdle);
         r_done     <= w_done_d;
         r_ovr      <= w_ovr_d;
         r_abt      <= w_abt_d;
      end
   end

endmodule

// File: tb/tb_ebr_spi_reader.sv
// Scoreboard bench for ebr_spi_reader: expected miso bytes and EBR read addresses are queued
// by the stimulus and popped by independent monitors.
module tb_ebr_spi_reader;

   logic       xclk = 1'b0;
   logic       rstn = 1'b0;
   logic       sck = 1'b0;
   logic       scsn = 1'b1;
   logic       lineValid = 1'b0;
   logic [9:0] lineLen = '0;
   logic [7:0] ebrRData = '0;
   logic       miso, misoOe, ebrRE, lineDone, overrun, aborted;
   logic [8:0] ebrRAddr;

   logic [7:0] mem [512];
   logic [7:0] exp_bytes [$];
   int         exp_addr [$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_done = 0;
   int         n_ovr = 0;
   int         n_abt = 0;

   ebr_spi_reader dut (
      .xclk      (xclk),
      .rstn      (rstn),
      .sck       (sck),
      .scsn      (scsn),
      .miso      (miso),
      .misoOe    (misoOe),
      .lineValid (lineValid),
      .lineLen   (lineLen),
      .ebrRAddr  (ebrRAddr),
      .ebrRE     (ebrRE),
      .ebrRData  (ebrRData),
      .lineDone  (lineDone),
      .overrun   (overrun),
      .aborted   (aborted)
   );

   always #5 xclk = ~xclk;

   always @(posedge xclk) if (ebrRE) ebrRData <= mem[ebrRAddr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SPI byte monitor: mode 0, sample on rising sck, partial bytes dropped at scsn rise.
   initial begin : mon_spi
      logic [7:0] sh;
      int         bits;
      sh   = '0;
      bits = 0;
      forever begin
         @(posedge sck or posedge scsn);
         if (scsn) begin
            bits = 0;
         end else begin
            sh = {sh[6:0], miso};
            bits++;
            if (bits == 8) begin
               bits = 0;
               if (exp_bytes.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL miso byte: got %0h expected none", sh);
               end else begin
                  chk("miso byte", {24'h0, sh}, {24'h0, exp_bytes.pop_front()});
               end
            end
         end
      end
   end

   // Pulse counters and EBR read-address scoreboard.
   initial begin : mon_side
      forever begin
         @(negedge xclk);
         if (lineDone) n_done++;
         if (overrun) n_ovr++;
         if (aborted) n_abt++;
         if (ebrRE) begin
            if (exp_addr.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL ebr addr: got %0h expected none", ebrRAddr);
            end else begin
               chk("ebr addr", {23'h0, ebrRAddr}, exp_addr.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   task automatic pulse_line(input int len);
      @(negedge xclk);
      lineValid = 1'b1;
      lineLen   = 10'(len);
      @(negedge xclk);
      lineValid = 1'b0;
      lineLen   = '0;
      repeat (2) @(negedge xclk);
   endtask

   task automatic spi_xfer(input int nbytes, input int extra_bits);
      @(negedge xclk);
      scsn = 1'b0;
      repeat (8) @(negedge xclk);
      chk("misoOe active", {31'h0, misoOe}, 32'h1);
      for (int i = 0; i < nbytes * 8 + extra_bits; i++) begin
         sck = 1'b1;
         repeat (4) @(negedge xclk);
         sck = 1'b0;
         repeat (4) @(negedge xclk);
      end
      scsn = 1'b1;
      repeat (10) @(negedge xclk);
      chk("misoOe idle", {31'h0, misoOe}, 32'h0);
   endtask

   task automatic clear_counts();
      n_done = 0;
      n_ovr  = 0;
      n_abt  = 0;
   endtask

   task automatic chk_drained(input string name);
      chk({name, " bytes left"}, exp_bytes.size(), 0);
      chk({name, " addrs left"}, exp_addr.size(), 0);
   endtask

   task automatic load_small();
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      mem[2] = 8'h33;
      mem[3] = 8'h44;
   endtask

   initial begin : main
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge xclk);
      chk("rst miso", {31'h0, miso}, 0);
      chk("rst misoOe", {31'h0, misoOe}, 0);
      chk("rst ebrRAddr", {23'h0, ebrRAddr}, 0);
      chk("rst ebrRE", {31'h0, ebrRE}, 0);
      chk("rst pulses", {29'h0, lineDone, overrun, aborted}, 0);
      rstn = 1'b1;
      repeat (5) @(negedge xclk);

      // 1: four-byte line, six-byte transaction
      load_small();
      clear_counts();
      pulse_line(4);
      exp_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
      exp_addr  = '{0, 1, 2, 3};
      spi_xfer(6, 0);
      chk_drained("t1");
      chk("t1 lineDone", n_done, 1);
      chk("t1 aborted", n_abt, 0);

      // 2: nothing pending
      clear_counts();
      exp_bytes = '{8'hFF, 8'hFF};
      spi_xfer(2, 0);
      chk_drained("t2");
      chk("t2 lineDone", n_done, 0);
      chk("t2 aborted", n_abt, 0);

      // 3: abort after two bytes plus a partial byte, then a full retry
      clear_counts();
      pulse_line(4);
      exp_bytes = '{8'hA5, 8'h11};
      exp_addr  = '{0, 1, 2};
      spi_xfer(2, 3);
      chk_drained("t3a");
      chk("t3 aborted", n_abt, 1);
      chk("t3a lineDone", n_done, 0);
      exp_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
      exp_addr  = '{0, 1, 2, 3};
      spi_xfer(5, 0);
      chk_drained("t3b");
      chk("t3b lineDone", n_done, 1);
      chk("t3b aborted", n_abt, 1);

      // 4: second lineValid while pending is an overrun; first length kept
      clear_counts();
      pulse_line(2);
      pulse_line(3);
      chk("t4 overrun", n_ovr, 1);
      exp_bytes = '{8'hA5, 8'h11, 8'h22, 8'hFF};
      exp_addr  = '{0, 1};
      spi_xfer(4, 0);
      chk_drained("t4");
      chk("t4 lineDone", n_done, 1);

      // 5: full 512-byte line, then 600 clamped to 512
      for (int i = 0; i < 512; i++) mem[i] = 8'(i);
      for (int pass = 0; pass < 2; pass++) begin
         clear_counts();
         pulse_line(pass == 0 ? 512 : 600);
         exp_bytes.push_back(8'hA5);
         for (int i = 0; i < 512; i++) begin
            exp_bytes.push_back(8'(i));
            exp_addr.push_back(i);
         end
         spi_xfer(513, 0);
         chk_drained(pass == 0 ? "t5 512" : "t5 600");
         chk("t5 lineDone", n_done, 1);
         chk("t5 ebrRAddr end", {23'h0, ebrRAddr}, 32'h1FF);
         chk("t5 overrun", n_ovr, 0);
      end

      // 6: reset in the middle of DATA
      load_small();
      clear_counts();
      pulse_line(4);
      exp_bytes = '{8'hA5, 8'h11, 8'h22};
      exp_addr  = '{0, 1, 2, 3};
      @(negedge xclk);
      scsn = 1'b0;
      repeat (8) @(negedge xclk);
      for (int i = 0; i < 26; i++) begin
         sck = 1'b1;
         repeat (4) @(negedge xclk);
         sck = 1'b0;
         repeat (4) @(negedge xclk);
      end
      rstn = 1'b0;
      #1;
      chk("t6 rst miso", {31'h0, miso}, 0);
      chk("t6 rst misoOe", {31'h0, misoOe}, 0);
      chk("t6 rst ebrRAddr", {23'h0, ebrRAddr}, 0);
      repeat (4) @(negedge xclk);
      scsn = 1'b1;
      repeat (4) @(negedge xclk);
      rstn = 1'b1;
      repeat (6) @(negedge xclk);
      chk_drained("t6a");
      exp_bytes = '{8'hFF};
      spi_xfer(1, 0);
      chk_drained("t6b");
      chk("t6 lineDone", n_done, 0);
      chk("t6 aborted", n_abt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
